compare_branch: RTL and testbench
=================================

# compare_branch

Clocked, parametrised successor to the asynchronous equality branch block: on a request it compares two latched operands and fires exactly one of two one-cycle branch pulses, `taken` or `notTaken`. It supports four relations: EQ, NE, LT and GE. Each relation can be signed or unsigned. The comparison runs MSB-first, `Digit` bits per cycle, with optional early exit. The block sits in the flow-control layer, driving conditional branches in synchronous pipelines.

## Interface
- `Width`, 32, operand width in bits.
- `Digit`, 8, bits compared per cycle. `Width % Digit` must be 0; otherwise elaboration fails with `$error`.
- `EarlyExit`, 1, controls when a result is issued:
  - 1: issue the result as soon as it is decided.
  - 0: always scan all digits (constant time).
- `clk  input  1  clock; all state changes on the rising edge`
- `rst_n  input  1  synchronous, active-low reset`
- `req  input  1  start request; sampled on the rising edge while idle`
- `mode  input  2  relation: 00 EQ, 01 NE, 10 LT (x<y), 11 GE (x>=y)`
- `sgn  input  1  1 = two's-complement compare, 0 = unsigned`
- `x  input  Width  left operand`
- `y  input  Width  right operand`
- `busy  output  1  high while a compare is in progress`
- `taken  output  1  one-cycle pulse: relation true`
- `notTaken  output  1  one-cycle pulse: relation false`
- `eqFlag  output  1  x==y for the last completed compare; held until the next result`
- `ltFlag  output  1  x<y (per sgn) for the last completed compare; held until the next result`

## Operation
- N = Width/Digit digits. Digit N-1 is the most significant.
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- IDLE, `req`=1 at an edge:
  - Latch `x`, `y`, `mode`, `sgn`. When `sgn`=1, invert bit Width-1 of both latched operands; a signed compare then reduces to unsigned.
  - Clear the digit index to N-1 and the decided/lt registers.
  - Go to RUN.
- IDLE, `req`=0: stay in IDLE.
- RUN, each edge, examine digit index d:
  - If no difference has been recorded and the digits differ: record decided=1, lt=(xd<yd).
  - Result condition: (EarlyExit=1 and the digits differ) or d==0.
  - If the result condition holds:
    - Go to IDLE.
    - `eqFlag` = not decided.
    - `ltFlag` = lt.
    - Pulse `taken` if the relation holds, else pulse `notTaken`.
  - Otherwise decrement d and stay in RUN.
- Relation evaluation: EQ = eq; NE = !eq; LT = lt; GE = !lt.
- `req` while RUN is ignored. It is not queued.
- Exactly one of `taken`/`notTaken` pulses per accepted request. They are never high together and are never high for two consecutive cycles from the same request.
- Inputs `x`, `y`, `mode`, `sgn` may change freely after the accept edge.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`, `taken`, `notTaken`, `eqFlag`, `ltFlag` all go to 0.
  - Internal operand, index and decided registers are cleared.
- Reset has priority over `req`.
- Reset mid-RUN aborts the compare; no result pulse is ever produced for it.
- Accept at edge E0. `busy`=1 after E0.
- Result at edge Ek, where:
  - k = 1 + (N-1 - index of the first differing digit) when EarlyExit=1 and the operands differ;
  - k = N otherwise.
- Latency bounds: 1 ≤ k ≤ N.
- At edge Ek:
  - `busy` drops to 0.
  - The result pulse and both flags update.
  - The pulse falls at E(k+1).
- Back-to-back: `req`=1 sampled at E(k+1) (first edge in IDLE) is accepted. Sustained throughput is one compare per k+1 cycles.
- Digit==Width (N=1): every compare completes at E1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Default params, EQ, x=y=0x12345678: accept at E0 → `taken` pulse at E4, `eqFlag`=1, `ltFlag`=0, `busy` high for E0..E3.
- NE, x=0x80000000, y=0: `taken` at E1, `eqFlag`=0. Repeat with EarlyExit=0: same result at E4.
- LT, x=0xFFFFFFFF, y=0x00000001:
  - `sgn`=1 → `taken` at E1, `ltFlag`=1.
  - `sgn`=0 → `notTaken` at E1, `ltFlag`=0.
- GE, x=0x00000100, y=0x00000101: first difference in digit 0 → `notTaken` at E4, `ltFlag`=1.
- `req` held high continuously with x=y=0: accepts at E0, E5, E10, with results at E4, E9, E14. Requests during RUN produce no extra pulses.
- `rst_n`=0 at E2 of a 4-cycle compare: all outputs 0 from E2. No pulse at any later edge. A new `req` accepted at the first edge after reset releases completes normally.

Source files
------------

// File: rtl/compare_branch.sv
// Clocked MSB-first magnitude/equality compare that fires one taken/notTaken branch pulse per request.
// Latency: result k edges after accept (1..N, N = Width/Digit); N edges when EarlyExit=0 or operands are equal.
// Backpressure: none queued; req is only sampled while idle (busy=0), requests during a compare are dropped.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req, mode, sgn      start request, relation (00 EQ, 01 NE, 10 LT, 11 GE), signed select
//   x, y                operands, latched on the accept edge
//   busy                compare in progress
//   taken, notTaken     one-cycle result pulses (exactly one per accepted request)
//   eqFlag, ltFlag      equality / less-than of the last completed compare, held
module compare_branch #(
  parameter int Width     = 32,
  parameter int Digit     = 8,
  parameter int EarlyExit = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       mode,
  input  logic             sgn,
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y,
  output logic             busy,
  output logic             taken,
  output logic             notTaken,
  output logic             eqFlag,
  output logic             ltFlag
);

  localparam int N  = Width / Digit;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (Width % Digit != 0) begin : g_bad_digit
      $error("compare_branch: Width must be a multiple of Digit");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [Width-1:0] x_r, y_r;
  logic [1:0]      mode_r;
  logic [IW-1:0]   idx;
  logic            decided, lt_r;

  logic [Digit-1:0] x_dig, y_dig;
  logic            differ, dec_nxt, lt_nxt, eq_nxt, rel, finish, accept;

  // Operands viewed as an array of digits so the current digit is a plain index.
  generate
    if (N == 1) begin : g_single
      assign x_dig = x_r;
      assign y_dig = y_r;
    end else begin : g_multi
      logic [N-1:0][Digit-1:0] x_arr, y_arr;
      assign x_arr = x_r;
      assign y_arr = y_r;
      assign x_dig = x_arr[idx];
      assign y_dig = y_arr[idx];
    end
  endgenerate

  always_comb begin
    differ  = (x_dig != y_dig);
    // Only the most significant differing digit decides the ordering.
    dec_nxt = decided | differ;
    lt_nxt  = decided ? lt_r : (x_dig < y_dig);
    eq_nxt  = ~dec_nxt;
    finish  = (state == RUN) && (((EarlyExit != 0) && differ) || (idx == '0));
    accept  = (state == IDLE) && req;
    case (mode_r)
      2'b00:   rel = eq_nxt;
      2'b01:   rel = ~eq_nxt;
      2'b10:   rel = lt_nxt;
      default: rel = ~lt_nxt;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req)    state_nxt = RUN;
      RUN:  if (finish) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r      <= '0;
      y_r      <= '0;
      mode_r   <= '0;
      idx      <= '0;
      decided  <= 1'b0;
      lt_r     <= 1'b0;
      taken    <= 1'b0;
      notTaken <= 1'b0;
      eqFlag   <= 1'b0;
      ltFlag   <= 1'b0;
    end else begin
      taken    <= 1'b0;
      notTaken <= 1'b0;
      if (accept) begin
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        x_r     <= x ^ {sgn, {(Width-1){1'b0}}};
        y_r     <= y ^ {sgn, {(Width-1){1'b0}}};
        mode_r  <= mode;
        idx     <= IW'(N - 1);
        decided <= 1'b0;
        lt_r    <= 1'b0;
      end else if (state == RUN) begin
        decided <= dec_nxt;
        lt_r    <= lt_nxt;
        if (finish) begin
          taken    <= rel;
          notTaken <= ~rel;
          eqFlag   <= eq_nxt;
          ltFlag   <= lt_nxt;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_compare_branch.sv
module tb_compare_branch;

  localparam int W = 32;
  localparam int DG [3] = '{8, 8, 32};
  localparam int EE [3] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  mode;
  logic        sgn;
  logic [W-1:0] x, y;

  logic [2:0] busy_v, tk_v, nt_v, eq_v, lt_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compare_branch #(.Width(W), .Digit(8), .EarlyExit(1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .sgn(sgn), .x(x), .y(y),
    .busy(busy_v[0]), .taken(tk_v[0]), .notTaken(nt_v[0]), .eqFlag(eq_v[0]), .ltFlag(lt_v[0]));

  compare_branch #(.Width(W), .Digit(8), .EarlyExit(0)) dut_ct (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .sgn(sgn), .x(x), .y(y),
    .busy(busy_v[1]), .taken(tk_v[1]), .notTaken(nt_v[1]), .eqFlag(eq_v[1]), .ltFlag(lt_v[1]));

  compare_branch #(.Width(W), .Digit(32), .EarlyExit(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .sgn(sgn), .x(x), .y(y),
    .busy(busy_v[2]), .taken(tk_v[2]), .notTaken(nt_v[2]), .eqFlag(eq_v[2]), .ltFlag(lt_v[2]));

  task automatic chk(input string nm, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %b expected %b", nm, i, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: {relation, equal, less} straight from arithmetic.
  function automatic logic [2:0] evalr(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] m, input logic s);
    logic e, l, r;
    e = (a == b);
    l = s ? ($signed(a) < $signed(b)) : (a < b);
    case (m)
      2'd0:    r = e;
      2'd1:    r = !e;
      2'd2:    r = l;
      default: r = !l;
    endcase
    return {r, e, l};
  endfunction

  // Reference latency: edges from accept to result.
  function automatic int kof(input logic [31:0] a, input logic [31:0] b, input int dg, input int ee);
    int n;
    logic [63:0] mask, da, db;
    n = 32 / dg;
    mask = (64'd1 << dg) - 64'd1;
    if (ee == 0 || a == b) return n;
    for (int d = n - 1; d >= 0; d--) begin
      da = (64'(a) >> (d * dg)) & mask;
      db = (64'(b) >> (d * dg)) & mask;
      if (da != db) return 1 + (n - 1 - d);
    end
    return n;
  endfunction

  // Behavioural model: countdown to a precomputed result, checked every cycle.
  int   cnt [3];
  logic [2:0] m_busy, m_tk, m_nt, m_eq, m_lt, p_rel, p_eq, p_lt;

  always @(posedge clk) begin
    logic [2:0] r;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cnt[i] = 0; m_busy[i] = 0; m_tk[i] = 0; m_nt[i] = 0; m_eq[i] = 0; m_lt[i] = 0;
      end else begin
        m_tk[i] = 0; m_nt[i] = 0;
        if (m_busy[i]) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) begin
            m_busy[i] = 0;
            m_tk[i] = p_rel[i];
            m_nt[i] = !p_rel[i];
            m_eq[i] = p_eq[i];
            m_lt[i] = p_lt[i];
          end
        end else if (req) begin
          r = evalr(x, y, mode, sgn);
          p_rel[i] = r[2]; p_eq[i] = r[1]; p_lt[i] = r[0];
          cnt[i] = kof(x, y, DG[i], EE[i]);
          m_busy[i] = 1;
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("busy", i, busy_v[i], m_busy[i]);
      chk("taken", i, tk_v[i], m_tk[i]);
      chk("notTaken", i, nt_v[i], m_nt[i]);
      chk("eqFlag", i, eq_v[i], m_eq[i]);
      chk("ltFlag", i, lt_v[i], m_lt[i]);
    end
  end

  // One request with hand-computed expectations for all three instances.
  task automatic directed(input string nm, input logic [1:0] m, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic e_rel, input logic e_eq, input logic e_lt,
                          input int k0, input int k1);
    int   kk [3];
    logic rtk [3], req_eq [3], rlt [3];
    int   kexp [3];
    kexp = '{k0, k1, 1};
    for (int i = 0; i < 3; i++) begin kk[i] = 0; rtk[i] = 0; req_eq[i] = 0; rlt[i] = 0; end
    @(negedge clk);
    req = 1; mode = m; sgn = s; x = a; y = b;
    @(negedge clk);
    req = 0; x = $urandom; y = $urandom;
    mode = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (kk[i] == 0 && (tk_v[i] || nt_v[i])) begin
          kk[i] = c; rtk[i] = tk_v[i]; req_eq[i] = eq_v[i]; rlt[i] = lt_v[i];
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk_int({nm, "_latency"}, kk[i], kexp[i]);
      chk({nm, "_taken"}, i, rtk[i], e_rel);
      chk({nm, "_eq"}, i, req_eq[i], e_eq);
      chk({nm, "_lt"}, i, rlt[i], e_lt);
    end
  endtask

  initial begin
    int q [$];
    int pulses;
    logic [31:0] rx;
    int sel;

    rst_n = 0; req = 0; mode = 0; sgn = 0; x = 0; y = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;

    directed("eq_equal",   2'b00, 1'b0, 32'h12345678, 32'h12345678, 1, 1, 0, 4, 4);
    directed("ne_msb",     2'b01, 1'b0, 32'h80000000, 32'h00000000, 1, 0, 0, 1, 4);
    directed("lt_signed",  2'b10, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1, 0, 1, 1, 4);
    directed("lt_unsign",  2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 1, 4);
    directed("ge_lowdig",  2'b11, 1'b0, 32'h00000100, 32'h00000101, 0, 0, 1, 4, 4);

    // req held high: accept every k+1 cycles on the 4-digit early-exit instance.
    @(negedge clk);
    req = 1; mode = 2'b00; sgn = 0; x = 0; y = 0;
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (tk_v[0]) q.push_back(c);
    end
    @(negedge clk) req = 0;
    chk_int("held_pulses", q.size(), 3);
    for (int j = 0; j < q.size() && j < 3; j++) chk_int("held_edge", q[j], 4 + 5 * j);
    repeat (6) @(posedge clk);

    // Reset at E2 of a 4-cycle compare aborts it without a pulse.
    @(negedge clk);
    req = 1; mode = 2'b00; sgn = 0; x = 32'hA5A5A5A5; y = 32'hA5A5A5A5;
    @(negedge clk) req = 0;
    @(negedge clk) rst_n = 0;
    @(posedge clk); #1;
    chk("abort_busy", 0, busy_v[0], 1'b0);
    @(negedge clk) rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      pulses += int'(tk_v[0]) + int'(nt_v[0]) + int'(tk_v[1]) + int'(nt_v[1]);
    end
    chk_int("abort_no_pulse", pulses, 0);
    directed("post_reset", 2'b00, 1'b0, 32'h5, 32'h5, 1, 1, 0, 4, 4);

    // Randomised traffic, including near-equal operands and sporadic resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      req   = ($urandom_range(0, 2) == 0);
      mode  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      rx    = $urandom;
      sel   = $urandom_range(0, 3);
      x     = rx;
      if (sel == 0)      y = rx;
      else if (sel == 1) y = rx ^ (32'd1 << $urandom_range(0, 31));
      else if (sel == 2) y = {rx[31:8], 8'($urandom)};
      else               y = $urandom;
    end
    @(negedge clk);
    rst_n = 1; req = 0;
    repeat (8) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
